// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter.
// Covers datapath widths, opcode constants, the write-source encoding
// and a helper that decides whether a destination produces a real write.
package wb_port_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Major opcodes of the instruction classes that reach write-back
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    // Which requester owns the write port in a given cycle
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_LOAD = 2'd1,
        SRC_BUF  = 2'd2,
        SRC_ALU  = 2'd3
    } wb_src_e;

    // x0 is hard-wired to zero, so writes to it are retired silently
    function automatic logic wr_allowed(input logic [REG_ADDR_W-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// In-order buffer of {rd, data} for ALU results that lost arbitration.
// Head is visible combinationally; every occupied entry also reports
// whether its rd matches a query rd so a stale load can be dropped.
module wb_skid_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int RD_W   = REG_ADDR_W
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [RD_W-1:0]              i_push_rd,
    input  logic [DATA_W-1:0]            i_push_data,
    input  logic                         i_pop,
    output logic [RD_W-1:0]              o_head_rd,
    output logic [DATA_W-1:0]            o_head_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    input  logic [RD_W-1:0]              i_match_rd,
    output logic [DEPTH-1:0]             o_match
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [RD_W-1:0]   rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              push_ok;
    logic              pop_ok;

    assign o_full      = (count_reg == CNT_W'(DEPTH));
    assign o_empty     = (count_reg == '0);
    assign o_count     = count_reg;
    assign push_ok     = i_push & ~o_full;
    assign pop_ok      = i_pop & ~o_empty;
    assign o_head_rd   = rd_mem[rd_ptr_reg];
    assign o_head_data = data_mem[rd_ptr_reg];

    // Pointer and occupancy bookkeeping; DEPTH is a power of 2 so pointers wrap naturally
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Entry payload needs no reset; its valid bit guards every use
            always_ff @(posedge i_clk) begin
                if (push_ok && wr_ptr_reg == PTR_W'(gi)) begin
                    rd_mem[gi]   <= i_push_rd;
                    data_mem[gi] <= i_push_data;
                end
            end

            // Occupancy flag per slot: cleared on pop, set on push
            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    valid_reg[gi] <= 1'b0;
                end else begin
                    if (pop_ok && rd_ptr_reg == PTR_W'(gi))
                        valid_reg[gi] <= 1'b0;
                    if (push_ok && wr_ptr_reg == PTR_W'(gi))
                        valid_reg[gi] <= 1'b1;
                end
            end

            assign o_match[gi] = valid_reg[gi] & (rd_mem[gi] == i_match_rd);
        end
    endgenerate

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port sequencer: loads always win, ALU results that lose are
// parked in an in-order buffer and drained on idle cycles. A load older
// than a buffered or concurrent ALU result to the same rd is discarded.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int XLEN  = wb_port_arbiter_pkg::XLEN,
    parameter int DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_halt,
    input  logic                  i_alu_valid,
    input  logic [REG_ADDR_W-1:0] i_alu_rd,
    input  logic [XLEN-1:0]       i_alu_data,
    input  logic                  i_ld_valid,
    input  logic [REG_ADDR_W-1:0] i_ld_rd,
    input  logic [XLEN-1:0]       i_ld_data,
    output logic                  o_alu_stall,
    output logic                  o_reg_wr_en,
    output logic [REG_ADDR_W-1:0] o_reg_wr_addr,
    output logic [XLEN-1:0]       o_reg_wr_data
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;
    logic                  buf_full;
    logic                  buf_empty;
    logic [CNT_W-1:0]      buf_count;
    logic [DEPTH-1:0]      buf_match;

    logic                  alu_acc;
    logic                  ld_drop;
    wb_src_e               src;
    logic                  push;
    logic                  pop;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;
    logic                  wr_en_next;

    logic                  wr_en_reg;
    logic [REG_ADDR_W-1:0] wr_addr_reg;
    logic [XLEN-1:0]       wr_data_reg;

    wb_skid_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (XLEN),
        .RD_W   (REG_ADDR_W)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push),
        .i_push_rd   (i_alu_rd),
        .i_push_data (i_alu_data),
        .i_pop       (pop),
        .o_head_rd   (head_rd),
        .o_head_data (head_data),
        .o_full      (buf_full),
        .o_empty     (buf_empty),
        .o_count     (buf_count),
        .i_match_rd  (i_ld_rd),
        .o_match     (buf_match)
    );

    // Stall never looks at a same-cycle pop, so a full buffer always stalls
    assign o_alu_stall = (buf_count == CNT_W'(DEPTH)) | i_halt;
    assign alu_acc     = i_alu_valid & ~o_alu_stall;
    assign ld_drop     = (|buf_match) | (alu_acc & (i_alu_rd == i_ld_rd));

    // Priority selection: live load, then buffer head, then direct ALU
    always_comb begin
        src      = SRC_NONE;
        sel_rd   = '0;
        sel_data = '0;
        push     = 1'b0;
        pop      = 1'b0;
        if (!i_halt) begin
            if (i_ld_valid && !ld_drop) begin
                src      = SRC_LOAD;
                sel_rd   = i_ld_rd;
                sel_data = i_ld_data;
            end else if (!buf_empty) begin
                src      = SRC_BUF;
                sel_rd   = head_rd;
                sel_data = head_data;
                pop      = 1'b1;
            end else if (alu_acc) begin
                src      = SRC_ALU;
                sel_rd   = i_alu_rd;
                sel_data = i_alu_data;
            end
            push = alu_acc & (src != SRC_ALU);
        end
        wr_en_next = (src != SRC_NONE) & wr_allowed(sel_rd);
    end

    // Registered write port; address/data refresh only when a source retires
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg <= wr_en_next;
            if (src != SRC_NONE) begin
                wr_addr_reg <= sel_rd;
                wr_data_reg <= sel_data;
            end
        end
    end

    assign o_reg_wr_en   = wr_en_reg;
    assign o_reg_wr_addr = wr_addr_reg;
    assign o_reg_wr_data = wr_data_reg;

    // Full flag is implied by count; kept as a named net for readability in waves
    logic unused_full;
    assign unused_full = buf_full;

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Sequencer for the single register-file write port at the end of the pipeline. Two requesters compete for the port: the ALU result path and the load-return path. Load data cannot be back-pressured, so it always wins. ALU results that lose arbitration are parked in a small in-order buffer and drained on idle cycles. The block drives the registered write enable, address and data into the register file, and drives a stall back to the execute stage when the buffer fills.

## Interface
Parameters
- XLEN, 32, data width (shared package value)
- DEPTH, 2, ALU pending-buffer entries (power of 2, ≥2)

Ports (one clock; reset is asynchronous and active-low)
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active low
- i_halt  in  1  freeze: no write issued, buffer held, stall asserted
- i_alu_valid  in  1  ALU result offered this cycle
- i_alu_rd  in  5  ALU destination register
- i_alu_data  in  XLEN  ALU result
- i_ld_valid  in  1  load data returning this cycle
- i_ld_rd  in  5  load destination register
- i_ld_data  in  XLEN  load data
- o_alu_stall  out  1  ALU offer not accepted; upstream holds it
- o_reg_wr_en  out  1  register-file write strobe
- o_reg_wr_addr  out  5  write address
- o_reg_wr_data  out  XLEN  write data

## Operation
- An ALU offer is accepted when i_alu_valid=1 and o_alu_stall=0. Load offers are always consumed.
- o_alu_stall is combinational: (count==DEPTH) | i_halt. An offer while stalled is ignored, not stored.
- Ordering rule: a load on the load path is always older than any buffered or concurrent ALU result.
- Per-cycle selection when i_halt=0, in priority order:
  1. load valid and not dropped → write the load;
  2. else buffer non-empty → pop the head and write it;
  3. else ALU accepted → write the ALU result directly (no buffering).
- An accepted ALU result that is not written this cycle is pushed to the buffer tail. Push and pop in the same cycle are allowed when count<DEPTH.
- Drop rule: a load whose rd equals the rd of any valid buffer entry, or of a concurrently accepted ALU result, is discarded. The younger value must survive. The cycle then falls to priority 2 or 3.
- rd==0: the write is suppressed (o_reg_wr_en=0). An x0 ALU result still occupies its buffer slot and pop slot, and is retired without a write.
- i_halt=1: no pop, no push, no write. A load arriving during halt is discarded, because upstream guarantees no loads during halt.
- Buffer count range is 0..DEPTH. Pointers wrap modulo DEPTH.

## Timing
- Reset values: o_reg_wr_en=0, o_reg_wr_addr=0, o_reg_wr_data=0, buffer empty, pointers 0. o_alu_stall follows i_halt during reset.
- Write outputs are registered. A winning request at cycle N appears on o_reg_wr_* at edge N+1 and holds for one cycle.
- Worst-case ALU latency is 1 + (load-busy cycles) + (buffer occupancy ahead).
- Reset asserted mid-operation: outputs clear immediately and buffered results are lost. Upstream flushes alongside.
- Full buffer with a simultaneous pop: stall is still asserted that cycle. Acceptance is never conditioned on a same-cycle pop.

## Structure
- Shared package: XLEN, REG_ADDR_W=5, opcode constants (STORE, LOAD, OP, OP_IMM).
- Sub-module wb_skid_fifo: DEPTH-entry FIFO of {rd, data} with push/pop/full/empty, count, and a parallel per-entry rd-match output used by the drop rule.
- The top level holds the priority mux, drop logic and output registers.

## Test plan
- Lone ALU: alu_valid, rd=5, data=0x11 → next cycle wr_en=1, addr=5, data=0x11; stall=0.
- Collision: load rd=3/0xAA and ALU rd=4/0xBB in the same cycle → writes rd3=0xAA, then rd4=0xBB on the following cycle.
- Fill: loads valid for 4 consecutive cycles with ALU offers every cycle → stall rises once count=2. After loads stop, the two buffered results drain in order, then direct writes resume.
- Same-rd drop: ALU rd=7/0x1 buffered, then load rd=7/0x2 → the load is dropped and the only write is rd7=0x1.
- x0: ALU rd=0/0xFF → wr_en stays 0 and the buffer slot is freed.
- Halt and reset: halt with 1 entry buffered → no write and stall=1; on halt release the entry drains. Reset asserted with 2 entries buffered → all outputs 0 and count=0.
